tge_tx_packetizer: RTL and testbench
====================================

// Module: tge_tx_packetizer
// PURPOSE
//  Application-side driver of the 10GbE core transmit interface (tx_valid/tx_end_of_frame/tx_data/tx_dest_*).
//  Cuts a continuous 64-bit sample stream into fixed-length UDP payloads.
//  Prepends one header word (sequence number + length) to each payload and honours tx_afull back-pressure.
//  Counts sent packets and core overflow events for software. Sits in the user clock domain next to the core.
// PARAMETERS
//  LEN_W      10  width of payload_len (max payload words = 2**LEN_W-1)
//  SEQ_W      48  width of header sequence number (SEQ_W + 16 = 64)
//  GAP_WORDS   2  idle cycles forced between end-of-frame and next header (0 allowed)
// PORTS
//  clk             in   1      user clock (same clock as core clk)
//  rst             in   1      asynchronous active-high reset
//  enable          in   1      start new packets while high; sampled only in IDLE
//  payload_len     in   LEN_W  payload words per packet, latched at packet start
//  dest_ip         in   32     destination IP, latched at packet start
//  dest_port       in   16     destination UDP port, latched at packet start
//  in_valid        in   1      sample word present
//  in_data         in   64     sample word
//  in_ready        out  1      sample word accepted when in_valid && in_ready
//  tx_valid        out  1      to core tx_valid
//  tx_end_of_frame out  1      to core tx_end_of_frame
//  tx_data         out  64     to core tx_data
//  tx_dest_ip      out  32     to core tx_dest_ip
//  tx_dest_port    out  16     to core tx_dest_port
//  tx_afull        in   1      from core; almost-full
//  tx_overflow     in   1      from core; word dropped
//  pkt_count       out  32     packets completed (wraps)
//  ovf_count       out  16     cycles with tx_overflow high (saturates at 16'hffff)
//  busy            out  1      state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, seq=0, all tx_* outputs, in_ready, busy=0, pkt_count=ovf_count=0.
//  - All tx_* outputs registered. A word is issued in cycle N+1 only if tx_afull=0 in cycle N.
//    One-cycle reaction latency absorbed by core afull margin.
//  - in_ready combinational: (state==PAY) && !tx_afull. Accepted word appears on tx_data next cycle.
//  - FSM:
//    IDLE: if enable && !tx_afull -> HDR. Latch len=payload_len, ip, port.
//    HDR: emit tx_data={seq,len zero-extended to 16}; seq<=seq+1 (wraps).
//      len==0: assert tx_end_of_frame on header -> GAP. Else -> PAY with remaining=len.
//    PAY: on each accepted word emit it and decrement remaining.
//      Word with remaining==1 carries tx_end_of_frame -> GAP.
//      No in_valid or tx_afull: stall with tx_valid=0. No timeout; frame stays open.
//    GAP: count GAP_WORDS cycles, then -> IDLE. GAP_WORDS=0 goes straight to IDLE.
//  - pkt_count increments in the cycle tx_end_of_frame is issued.
//  - tx_dest_ip/port hold latched values for the whole packet, including the EOF word.
//  - enable deasserted mid-packet: the current packet completes normally. No new packet starts.
//  - payload_len/dest changes mid-packet are ignored until next IDLE->HDR.
//  - tx_afull stays high in HDR: header is held (HDR issues only when !tx_afull of prior cycle).
//  - tx_overflow high and ovf_count<16'hffff: ovf_count+1. tx_overflow does not alter the FSM.
//  - Async reset mid-packet: outputs drop immediately. The core sees a truncated frame with no EOF;
//    the core's own reset is expected alongside.
// STRUCTURE
//  - Shared package tge_pkg: state encoding (IDLE/HDR/PAY/GAP), header field widths/offsets (SEQ_W, LEN field 16).
//  - Single module; no sub-module needed (FSM + three counters + output register).
// TESTING
//  1. len=4, enable=1, in_valid always, afull=0 -> frame: hdr(seq0,len4), 4 words, EOF on 5th.
//     GAP of 2 cycles, next hdr seq=1.
//  2. afull pulsed high 3 cycles mid-PAY -> tx_valid low 3 cycles (shifted +1).
//     No word lost or duplicated, in_ready low same cycles.
//  3. len=0 -> single header word with tx_end_of_frame=1, pkt_count+1, in_ready never high.
//  4. enable dropped after 2 of 8 payload words -> packet finishes 8 words + EOF.
//     FSM stays IDLE afterwards.
//  5. tx_overflow held 70000 cycles -> ovf_count=16'hffff, FSM unaffected.
//  6. rst asserted mid-PAY -> all outputs 0 same cycle. After release, first hdr seq=0, pkt_count=0.

Source files
------------

// File: rtl/tge_pkg.sv
// Shared definitions for the 10GbE transmit packetizer: FSM encoding and header word layout.
package tge_pkg;

    localparam int TGE_SEQ_W     = 48;
    localparam int TGE_LEN_FLD_W = 16;
    localparam int TGE_WORD_W    = TGE_SEQ_W + TGE_LEN_FLD_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // Header word: sequence number in the upper bits, payload length (words) in the low 16.
    function automatic logic [TGE_WORD_W-1:0] tge_hdr(input logic [TGE_SEQ_W-1:0]     seq,
                                                      input logic [TGE_LEN_FLD_W-1:0] len);
        return {seq, len};
    endfunction

endpackage

// File: rtl/tge_tx_packetizer.sv
// Packetizer: slices a 64-bit sample stream into UDP frames, each led by a {seq,len} header word.
// Latency: accepted sample appears on tx_data the next cycle; header one cycle after HDR entry.
// Backpressure: tx_afull in cycle N blocks issue in N+1; in_ready = PAY && !tx_afull, no frame timeout.
module tge_tx_packetizer
    import tge_pkg::*;
#(
    parameter int LEN_W     = 10,
    parameter int SEQ_W     = TGE_SEQ_W,
    parameter int GAP_WORDS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [LEN_W-1:0] payload_len,
    input  logic [31:0]      dest_ip,
    input  logic [15:0]      dest_port,
    input  logic             in_valid,
    input  logic [63:0]      in_data,
    output logic             in_ready,
    output logic             tx_valid,
    output logic             tx_end_of_frame,
    output logic [63:0]      tx_data,
    output logic [31:0]      tx_dest_ip,
    output logic [15:0]      tx_dest_port,
    input  logic             tx_afull,
    input  logic             tx_overflow,
    output logic [31:0]      pkt_count,
    output logic [15:0]      ovf_count,
    output logic             busy
);

    localparam int              GAP_CW       = (GAP_WORDS > 1) ? $clog2(GAP_WORDS) : 1;
    localparam logic [GAP_CW-1:0] GAP_LAST   = GAP_CW'((GAP_WORDS > 0) ? GAP_WORDS - 1 : 0);
    localparam logic [1:0]      ST_AFTER_EOF = (GAP_WORDS > 0) ? ST_GAP : ST_IDLE;

    logic [1:0]        state;
    logic [SEQ_W-1:0]  seq_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  remaining;
    logic [GAP_CW-1:0] gap_cnt;
    logic [31:0]       ip_q;
    logic [15:0]       port_q;
    logic              accept;

    assign in_ready     = (state == ST_PAY) && !tx_afull;
    assign accept       = in_valid && in_ready;
    assign busy         = (state != ST_IDLE);
    assign tx_dest_ip   = ip_q;
    assign tx_dest_port = port_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            seq_q           <= '0;
            len_q           <= '0;
            remaining       <= '0;
            gap_cnt         <= '0;
            ip_q            <= '0;
            port_q          <= '0;
            tx_valid        <= 1'b0;
            tx_end_of_frame <= 1'b0;
            tx_data         <= '0;
            pkt_count       <= '0;
        end else begin
            tx_valid        <= 1'b0;
            tx_end_of_frame <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Destination and length are frozen here for the whole frame.
                    if (enable && !tx_afull) begin
                        len_q  <= payload_len;
                        ip_q   <= dest_ip;
                        port_q <= dest_port;
                        state  <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!tx_afull) begin
                        tx_valid  <= 1'b1;
                        tx_data   <= tge_hdr(TGE_SEQ_W'(seq_q), TGE_LEN_FLD_W'(len_q));
                        seq_q     <= seq_q + SEQ_W'(1);
                        remaining <= len_q;
                        if (len_q == '0) begin
                            tx_end_of_frame <= 1'b1;
                            pkt_count       <= pkt_count + 32'd1;
                            gap_cnt         <= '0;
                            state           <= ST_AFTER_EOF;
                        end else begin
                            state <= ST_PAY;
                        end
                    end
                end
                ST_PAY: begin
                    if (accept) begin
                        tx_valid  <= 1'b1;
                        tx_data   <= in_data;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            tx_end_of_frame <= 1'b1;
                            pkt_count       <= pkt_count + 32'd1;
                            gap_cnt         <= '0;
                            state           <= ST_AFTER_EOF;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Overflow is only reported to software; it never disturbs the frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (tx_overflow && (ovf_count != 16'hffff)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_tge_tx_packetizer.sv
// Randomized scoreboard bench for tge_tx_packetizer: expected frames are queued at stimulus time
// and popped by an independent monitor whenever tx_valid is seen.
module tb_tge_tx_packetizer;

    localparam int LEN_W     = 10;
    localparam int GAP_WORDS = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic [LEN_W-1:0] payload_len = '0;
    logic [31:0]      dest_ip = '0;
    logic [15:0]      dest_port = '0;
    logic             in_valid = 1'b0;
    logic [63:0]      in_data = '0;
    logic             in_ready;
    logic             tx_valid;
    logic             tx_end_of_frame;
    logic [63:0]      tx_data;
    logic [31:0]      tx_dest_ip;
    logic [15:0]      tx_dest_port;
    logic             tx_afull = 1'b0;
    logic             tx_overflow = 1'b0;
    logic [31:0]      pkt_count;
    logic [15:0]      ovf_count;
    logic             busy;

    logic afull_force = 1'b0;
    logic afull_rand  = 1'b0;
    logic ovf_force   = 1'b0;
    logic ovf_rand    = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] dat;
        logic        eof;
        logic [31:0] ip;
        logic [15:0] port;
        logic        hdr;
    } exp_t;

    exp_t        exp_q[$];
    logic [47:0] seq_exp = '0;
    int          exp_pkts = 0;
    int          ovf_model = 0;

    always #5 clk = ~clk;

    tge_tx_packetizer #(.LEN_W(LEN_W), .SEQ_W(48), .GAP_WORDS(GAP_WORDS)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .payload_len     (payload_len),
        .dest_ip         (dest_ip),
        .dest_port       (dest_port),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .tx_valid        (tx_valid),
        .tx_end_of_frame (tx_end_of_frame),
        .tx_data         (tx_data),
        .tx_dest_ip      (tx_dest_ip),
        .tx_dest_port    (tx_dest_port),
        .tx_afull        (tx_afull),
        .tx_overflow     (tx_overflow),
        .pkt_count       (pkt_count),
        .ovf_count       (ovf_count),
        .busy            (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Core-side status lines change just after the rising edge.
    always @(posedge clk) begin
        #1;
        tx_afull    = afull_force || (afull_rand && ($urandom_range(0, 3) == 0));
        tx_overflow = ovf_force || (ovf_rand && ($urandom_range(0, 7) == 0));
    end

    // Monitor: every issued word must match the head of the expected stream.
    initial begin
        exp_t e;
        logic prev_afull;
        int   idle_run;
        prev_afull = 1'b0;
        idle_run   = 1000;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_afull = 1'b0;
                idle_run   = 1000;
                ovf_model  = 0;
            end else begin
                if (tx_valid) begin
                    chk("issue_after_afull", {63'd0, prev_afull}, 64'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h expected no word", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", tx_data, e.dat);
                        chk("word_eof", {63'd0, tx_end_of_frame}, {63'd0, e.eof});
                        chk("dest_ip", {32'd0, tx_dest_ip}, {32'd0, e.ip});
                        chk("dest_port", {48'd0, tx_dest_port}, {48'd0, e.port});
                        if (e.hdr) chk("gap_before_hdr", {63'd0, idle_run >= GAP_WORDS}, 64'd1);
                        if (e.eof) begin
                            exp_pkts++;
                            chk("pkt_count", {32'd0, pkt_count}, 64'(exp_pkts));
                        end
                    end
                    idle_run = 0;
                end else begin
                    idle_run++;
                end
                if (in_ready) chk("in_ready_vs_afull", {63'd0, tx_afull}, 64'd0);
                chk("ovf_count", {48'd0, ovf_count}, 64'(ovf_model));
                if (tx_overflow && ovf_model < 65535) ovf_model++;
                prev_afull = tx_afull;
            end
        end
    end

    // One frame: header expectation, then 'stop' payload words; en_drop = accepted words before enable falls.
    task automatic send_pkt(input int len, input int en_drop, input int stop, input int vprob);
        exp_t h;
        exp_t w;
        int   acc;
        int   guard;
        logic held;
        @(negedge clk);
        guard = 0;
        while (busy && guard < 500) begin @(negedge clk); guard++; end
        if (busy) chk("idle_wait_timeout", {63'd0, busy}, 64'd0);
        payload_len = LEN_W'(len);
        dest_ip     = $urandom;
        dest_port   = 16'($urandom);
        h.dat  = {seq_exp, 16'(len)};
        h.eof  = (len == 0);
        h.ip   = dest_ip;
        h.port = dest_port;
        h.hdr  = 1'b1;
        exp_q.push_back(h);
        seq_exp++;
        enable = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!busy && guard < 500);
        if (!busy) chk("start_timeout", {63'd0, busy}, 64'd1);
        if (en_drop == 0) enable = 1'b0;
        // Mid-frame changes must not leak into the frame in flight.
        payload_len = LEN_W'($urandom);
        dest_ip     = $urandom;
        dest_port   = 16'($urandom);
        acc = 0;
        guard = 0;
        held = 1'b0;
        while (acc < stop && guard < 5000) begin
            if (!held) begin
                in_valid = ($urandom_range(1, 100) <= vprob);
                in_data  = {$urandom, $urandom};
            end
            if (in_valid && in_ready) begin
                w.dat  = in_data;
                w.eof  = (acc == len - 1);
                w.ip   = h.ip;
                w.port = h.port;
                w.hdr  = 1'b0;
                exp_q.push_back(w);
                acc++;
                held = 1'b0;
                if (acc == en_drop) enable = 1'b0;
            end else begin
                held = in_valid;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        if (acc < stop) chk("payload_timeout", 64'(acc), 64'(stop));
        if (stop < len) begin
            enable = 1'b0;
            return;
        end
        guard = 0;
        while (busy && guard < 500) begin
            chk("in_ready_after_last", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
            guard++;
        end
        if (busy) chk("finish_timeout", {63'd0, busy}, 64'd0);
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stays_idle", {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        chk("rst_tx_eof", {63'd0, tx_end_of_frame}, 64'd0);
        chk("rst_tx_data", tx_data, 64'd0);
        chk("rst_dest_ip", {32'd0, tx_dest_ip}, 64'd0);
        chk("rst_dest_port", {48'd0, tx_dest_port}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_pkt_count", {32'd0, pkt_count}, 64'd0);
        chk("rst_ovf_count", {48'd0, ovf_count}, 64'd0);
        #2 rst = 1'b0;

        // Two back-to-back 4-word frames: seq 0 then 1, gap enforced.
        send_pkt(4, 0, 4, 100);
        send_pkt(4, 0, 4, 100);

        // afull pulse of 3 cycles in the middle of the payload.
        fork
            send_pkt(8, 0, 8, 100);
            begin
                repeat (6) @(negedge clk);
                afull_force = 1'b1;
                repeat (3) @(negedge clk);
                afull_force = 1'b0;
            end
        join

        // Header-only frame.
        send_pkt(0, 0, 0, 100);

        // enable falls after 2 of 8 words; the frame still completes.
        send_pkt(8, 2, 8, 100);

        afull_rand = 1'b1;
        ovf_rand   = 1'b1;
        for (int i = 0; i < 25; i++) begin
            int l;
            l = $urandom_range(0, 12);
            send_pkt(l, $urandom_range(0, l), l, $urandom_range(30, 100));
        end
        send_pkt(40, 5, 40, 70);
        afull_rand = 1'b0;
        ovf_rand   = 1'b0;

        // Long overflow burst saturates the counter without disturbing framing.
        ovf_force = 1'b1;
        send_pkt(5, 0, 5, 100);
        repeat (70000) @(negedge clk);
        ovf_force = 1'b0;
        repeat (2) @(negedge clk);
        chk("ovf_saturated", {48'd0, ovf_count}, 64'hffff);
        send_pkt(3, 0, 3, 100);

        // Reset in the middle of an open frame.
        send_pkt(8, 0, 3, 100);
        repeat (3) @(negedge clk);
        chk("drained_before_reset", 64'(exp_q.size()), 64'd0);
        chk("busy_mid_packet", {63'd0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        chk("mid_rst_tx_data", tx_data, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_pkt_count", {32'd0, pkt_count}, 64'd0);
        chk("mid_rst_ovf_count", {48'd0, ovf_count}, 64'd0);
        exp_q.delete();
        seq_exp  = '0;
        exp_pkts = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        send_pkt(3, 0, 3, 100);
        send_pkt(2, 1, 2, 60);
        repeat (5) @(negedge clk);
        chk("queue_empty_end", 64'(exp_q.size()), 64'd0);
        chk("final_pkt_count", {32'd0, pkt_count}, 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
